// File: rtl/cmp_pipe_if.sv
// -----------------------------------------------------------------------------
// cmp_pipe_if : request/result bundle for the cmp_pipe comparator.
//
//   in_valid / in_ready  : request handshake (producer -> comparator)
//   a, b                 : WIDTH-bit operands
//   op                   : relation select (eq, ne, lt, le, gt, ge; 110/111 reserved)
//   sgn                  : two's-complement compare request
//   out_valid / out_ready: result handshake (comparator -> consumer)
//   z, err               : relation result, reserved-op flag
//
// master : the producer/consumer side (drives requests, takes results)
// slave  : the comparator side
// -----------------------------------------------------------------------------
interface cmp_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic             z;
   logic             err;

   modport master (
      output in_valid, a, b, op, sgn, out_ready,
      input  in_ready, out_valid, z, err
   );

   modport slave (
      input  in_valid, a, b, op, sgn, out_ready,
      output in_ready, out_valid, z, err
   );
endinterface

// File: rtl/cmp_pipe.sv
// -----------------------------------------------------------------------------
// cmp_pipe : pipelined two-operand comparator with run-time relation select
//            and valid/ready flow control on both sides.
//
// Parameters
//   WIDTH  : operand width in bits (>= 1)
//   STAGES : pipeline depth in register stages (>= 1)
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears every stage valid and z/err
//   bus    : cmp_pipe_if slave modport (request in, result out)
//
// Build option
//   CMP_SIGNED_EN : when defined, sgn=1 selects a two's-complement less-than;
//                   when undefined, sgn is ignored and no sign logic exists.
//
// Structure
//   STAGES = 1 : inputs are compared and the relation is registered directly.
//   STAGES >= 2: STAGES-2 operand-only stages, then a stage registering the
//                eq/lt partials, then the final stage selecting the relation.
//   Every stage advances on adv = !out_valid || out_ready, so a stalled
//   result freezes the whole pipe (bubbles included).
// -----------------------------------------------------------------------------
module cmp_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic       clk,
   input logic       rst,
   cmp_pipe_if.slave bus
);

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
`ifdef CMP_SIGNED_EN
      logic             s;
`endif
   } req_t;

   logic adv;
   logic out_valid_reg;
   logic z_reg;
   logic err_reg;

   req_t in_req;
   req_t cmp_req;      // request the eq/lt partials are formed from
   logic cmp_eq;
   logic cmp_lt;

   // What the final (relation-select) stage sees
   logic       fin_v;
   logic       fin_eq;
   logic       fin_lt;
   logic [2:0] fin_op;

   assign adv           = !out_valid_reg || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_reg;
   assign bus.z         = z_reg;
   assign bus.err       = err_reg;

   always_comb begin
      in_req    = '0;
      in_req.v  = bus.in_valid;
      in_req.a  = bus.a;
      in_req.b  = bus.b;
      in_req.op = bus.op;
`ifdef CMP_SIGNED_EN
      in_req.s  = bus.sgn;
`endif
   end

   // ---------------------------------------------------------------- operands
   generate
      if (STAGES > 2) begin : g_opnd
         localparam int OPS = STAGES - 2;
         req_t opnd_reg [OPS];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < OPS; i++) begin
                  opnd_reg[i] <= '0;
               end
            end else if (adv) begin
               opnd_reg[0] <= in_req;
               for (int i = 1; i < OPS; i++) begin
                  opnd_reg[i] <= opnd_reg[i-1];
               end
            end
         end

         assign cmp_req = opnd_reg[OPS-1];
      end else begin : g_no_opnd
         assign cmp_req = in_req;
      end
   endgenerate

   // ---------------------------------------------------------------- compare
   always_comb begin
      cmp_eq = (cmp_req.a == cmp_req.b);
`ifdef CMP_SIGNED_EN
      cmp_lt = cmp_req.s ? ($signed(cmp_req.a) < $signed(cmp_req.b))
                         : (cmp_req.a < cmp_req.b);
`else
      cmp_lt = (cmp_req.a < cmp_req.b);
`endif
   end

   // ---------------------------------------------------------------- partials
   generate
      if (STAGES >= 2) begin : g_part
         logic       part_v_reg;
         logic       part_eq_reg;
         logic       part_lt_reg;
         logic [2:0] part_op_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               part_v_reg  <= 1'b0;
               part_eq_reg <= 1'b0;
               part_lt_reg <= 1'b0;
               part_op_reg <= 3'b000;
            end else if (adv) begin
               part_v_reg  <= cmp_req.v;
               part_eq_reg <= cmp_eq;
               part_lt_reg <= cmp_lt;
               part_op_reg <= cmp_req.op;
            end
         end

         assign fin_v  = part_v_reg;
         assign fin_eq = part_eq_reg;
         assign fin_lt = part_lt_reg;
         assign fin_op = part_op_reg;
      end else begin : g_no_part
         assign fin_v  = cmp_req.v;
         assign fin_eq = cmp_eq;
         assign fin_lt = cmp_lt;
         assign fin_op = cmp_req.op;
      end
   endgenerate

   // Returns {err, z}
   function automatic logic [1:0] relate(input logic [2:0] o,
                                         input logic       eq,
                                         input logic       lt);
      case (o)
         3'b000:  relate = {1'b0, eq};
         3'b001:  relate = {1'b0, !eq};
         3'b010:  relate = {1'b0, lt};
         3'b011:  relate = {1'b0, lt || eq};
         3'b100:  relate = {1'b0, !lt && !eq};
         3'b101:  relate = {1'b0, !lt};
         default: relate = 2'b10;
      endcase
   endfunction

   // ---------------------------------------------------------------- final
   // z/err only change when a real result arrives; a bubble leaves them as-is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         z_reg         <= 1'b0;
         err_reg       <= 1'b0;
      end else if (adv) begin
         out_valid_reg <= fin_v;
         if (fin_v) begin
            {err_reg, z_reg} <= relate(fin_op, fin_eq, fin_lt);
         end
      end
   end

endmodule

// File: tb/tb_cmp_pipe.sv
module tb_cmp_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef CMP_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   cmp_pipe_if #(.WIDTH(32)) ifa ();
   cmp_pipe_if #(.WIDTH(8))  ifb ();
   cmp_pipe_if #(.WIDTH(5))  ifc ();

   cmp_pipe #(.WIDTH(32), .STAGES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   cmp_pipe #(.WIDTH(8),  .STAGES(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   cmp_pipe #(.WIDTH(5),  .STAGES(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   // Reference: operands become integer values, then the relation is applied.
   // Returns {err, z}.
   function automatic logic [1:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [2:0] op,
                                        input logic sgn);
      longint va, vb;
      logic   eq, lt;
      va = longint'(a);
      vb = longint'(b);
      if (SIGNED_EN && sgn) begin
         if (a[w-1]) va = va - (longint'(1) << w);
         if (b[w-1]) vb = vb - (longint'(1) << w);
      end
      eq = (va == vb);
      lt = (va < vb);
      case (op)
         3'd0:    return {1'b0, eq};
         3'd1:    return {1'b0, !eq};
         3'd2:    return {1'b0, lt};
         3'd3:    return {1'b0, lt || eq};
         3'd4:    return {1'b0, va > vb};
         3'd5:    return {1'b0, va >= vb};
         default: return 2'b10;
      endcase
   endfunction

   task automatic idle_all();
      ifa.in_valid = 0; ifa.a = '0; ifa.b = '0; ifa.op = '0; ifa.sgn = 0; ifa.out_ready = 1;
      ifb.in_valid = 0; ifb.a = '0; ifb.b = '0; ifb.op = '0; ifb.sgn = 0; ifb.out_ready = 1;
      ifc.in_valid = 0; ifc.a = '0; ifc.b = '0; ifc.op = '0; ifc.sgn = 0; ifc.out_ready = 1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ifa.out_valid, ifa.z, ifa.err, ifa.in_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_a {out_valid,z,err,in_ready}: got %b want 0001",
                            {ifa.out_valid, ifa.z, ifa.err, ifa.in_ready});
      end
      checks++;
      if ({ifb.out_valid, ifb.z, ifb.err, ifb.in_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_b {out_valid,z,err,in_ready}: got %b want 0001",
                            {ifb.out_valid, ifb.z, ifb.err, ifb.in_ready});
      end
      checks++;
      if ({ifc.out_valid, ifc.z, ifc.err, ifc.in_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_c {out_valid,z,err,in_ready}: got %b want 0001",
                            {ifc.out_valid, ifc.z, ifc.err, ifc.in_ready});
      end
      // Two requests in flight, then an asynchronous reset mid-cycle
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         ifa.in_valid = 1; ifa.a = 32'd5; ifa.b = 32'd5; ifa.op = 3'd0;
      end
      @(posedge clk); #1;
      ifa.in_valid = 0;
      checks++;
      if (ifa.out_valid !== 1'b1) begin
         errors++; $display("FAIL inflight_before_reset out_valid: got %b want 1", ifa.out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ifa.out_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset out_valid: got %b want 0", ifa.out_valid);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ifa.out_valid, ifa.z, ifa.err, ifa.in_ready} !== 4'b0001) begin
         errors++; $display("FAIL after_reset {out_valid,z,err,in_ready}: got %b want 0001",
                            {ifa.out_valid, ifa.z, ifa.err, ifa.in_ready});
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL discarded_request cycle %0d out_valid: got %b want 0", c, ifa.out_valid);
         end
      end
   endtask

   task automatic test_full_rate();
      logic zexp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int   k;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c < 6) begin
            ifa.in_valid = 1; ifa.a = 32'd5; ifa.b = 32'd5; ifa.op = 3'(c); ifa.sgn = 1'($urandom);
         end else begin
            ifa.in_valid = 0;
         end
         @(negedge clk);
         checks++;
         if (ifa.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_rate in_ready cycle %0d: got %b want 1", c, ifa.in_ready);
         end
         k = c - 2;
         checks++;
         if (ifa.out_valid !== (k >= 0 && k < 6)) begin
            errors++; $display("FAIL full_rate out_valid cycle %0d: got %b want %b", c, ifa.out_valid, (k >= 0 && k < 6));
         end
         if (k >= 0 && k < 6) begin
            checks++;
            if ({ifa.err, ifa.z} !== {1'b0, zexp[k]}) begin
               errors++; $display("FAIL full_rate op %0d {err,z}: got %b want %b", k, {ifa.err, ifa.z}, {1'b0, zexp[k]});
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [2:0] ops [4] = '{3'd2, 3'd5, 3'd2, 3'd3};
      logic [1:0] q [$];
      int ptr = 0;
      int got = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         ifa.out_ready = !(c >= 2 && c <= 4);
         if (ptr < 4) begin
            ifa.in_valid = 1; ifa.a = 32'd3; ifa.b = 32'd7; ifa.op = ops[ptr]; ifa.sgn = 0;
         end else begin
            ifa.in_valid = 0;
         end
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (ifa.out_valid !== 1'b1) begin
               errors++; $display("FAIL bp_pipe_full out_valid: got %b want 1", ifa.out_valid);
            end
         end
         if (ifa.out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL bp_unexpected_result cycle %0d: got {err,z}=%b want none", c, {ifa.err, ifa.z});
            end else if ({ifa.err, ifa.z} !== q[0]) begin
               errors++; $display("FAIL bp_result cycle %0d {err,z}: got %b want %b", c, {ifa.err, ifa.z}, q[0]);
            end
            if (!ifa.out_ready) begin
               checks++;
               if (ifa.in_ready !== 1'b0) begin
                  errors++; $display("FAIL bp_stall in_ready cycle %0d: got %b want 0", c, ifa.in_ready);
               end
            end else if (q.size() > 0) begin
               void'(q.pop_front());
               got++;
            end
         end
         if (ifa.in_valid && ifa.in_ready) begin
            q.push_back(model(32, ifa.a, ifa.b, ifa.op, ifa.sgn));
            ptr++;
         end
      end
      checks++;
      if (got != 4 || q.size() != 0) begin
         errors++; $display("FAIL bp_delivered_count: got %0d (left %0d) want 4 (left 0)", got, q.size());
      end
   endtask

   task automatic test_signed_reserved();
      logic [31:0] av  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h8000_0000};
      logic [31:0] bv  [6] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF};
      logic [2:0]  opv [6] = '{3'd2, 3'd2, 3'd6, 3'd0, 3'd7, 3'd4};
      logic        sv  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0]  want [6];
      int k;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         if (c < 6) begin
            ifa.in_valid = 1; ifa.a = av[c]; ifa.b = bv[c]; ifa.op = opv[c]; ifa.sgn = sv[c];
            want[c] = model(32, av[c], bv[c], opv[c], sv[c]);
         end else begin
            ifa.in_valid = 0;
         end
         @(negedge clk);
         k = c - 2;
         if (k >= 0 && k < 6) begin
            checks++;
            if ({ifa.out_valid, ifa.err, ifa.z} !== {1'b1, want[k]}) begin
               errors++; $display("FAIL signed_reserved req %0d {out_valid,err,z}: got %b want %b",
                                  k, {ifa.out_valid, ifa.err, ifa.z}, {1'b1, want[k]});
            end
         end
      end
   endtask

   task automatic test_bubbles();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         ifb.in_valid = (c == 0 || c == 2);
         ifb.a = 8'h80; ifb.b = 8'h7F; ifb.op = 3'd4; ifb.sgn = 0;
         @(negedge clk);
         checks++;
         if (ifb.out_valid !== (c == 1 || c == 3)) begin
            errors++; $display("FAIL bubble out_valid cycle %0d: got %b want %b", c, ifb.out_valid, (c == 1 || c == 3));
         end
         if (c == 1 || c == 3) begin
            checks++;
            if ({ifb.err, ifb.z} !== 2'b01) begin
               errors++; $display("FAIL bubble {err,z} cycle %0d: got %b want 01", c, {ifb.err, ifb.z});
            end
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] q [$];
      int sent = 0;
      int got = 0;
      for (int c = 0; c < 430; c++) begin
         @(posedge clk); #1;
         if (c < 400) begin
            ifc.in_valid  = ($urandom_range(0, 9) < 7);
            ifc.out_ready = ($urandom_range(0, 9) < 7);
            ifc.a   = 5'($urandom);
            ifc.b   = ($urandom_range(0, 3) == 0) ? ifc.a : 5'($urandom);
            ifc.op  = 3'($urandom);
            ifc.sgn = 1'($urandom);
         end else begin
            ifc.in_valid  = 0;
            ifc.out_ready = 1;
         end
         @(negedge clk);
         if (ifc.out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected_result cycle %0d: got {err,z}=%b want none", c, {ifc.err, ifc.z});
            end else if ({ifc.err, ifc.z} !== q[0]) begin
               errors++; $display("FAIL rand_result cycle %0d {err,z}: got %b want %b", c, {ifc.err, ifc.z}, q[0]);
            end
            if (!ifc.out_ready) begin
               checks++;
               if (ifc.in_ready !== 1'b0) begin
                  errors++; $display("FAIL rand_stall in_ready cycle %0d: got %b want 0", c, ifc.in_ready);
               end
            end else if (q.size() > 0) begin
               void'(q.pop_front());
               got++;
            end
         end
         if (ifc.in_valid && ifc.in_ready) begin
            q.push_back(model(5, 32'(ifc.a), 32'(ifc.b), ifc.op, ifc.sgn));
            sent++;
         end
      end
      checks++;
      if (q.size() != 0 || got != sent) begin
         errors++; $display("FAIL rand_drain: delivered %0d of %0d (left %0d) want all", got, sent, q.size());
      end
      $display("random: %0d requests sent, %0d results delivered", sent, got);
   endtask

   initial begin
      idle_all();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      test_reset();
      test_full_rate();
      test_back_pressure();
      test_signed_reserved();
      test_bubbles();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
